mux2_arbiter: RTL

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/mux2_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter driving a shared 2:1 mux: grant one cycle after request, alternation on contention, forced rotation after MAX_HOLD cycles.
// f/f_valid are combinational from the registered select and live inputs; consumers cannot stall the grant.
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] f,
  output logic             f_valid
);

  typedef enum logic [1:0] {IDLE, GA, GB} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       s_q, s_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      hold_cnt_q   <= 4'd0;
      s_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      s_q          <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_grant_q ? GA : GB;
        else if (req_a)     state_d = GA;
        else if (req_b)     state_d = GB;
      end
      GA: begin
        if (!req_a)                                 state_d = req_b ? GB : IDLE;
        else if (req_b && hold_cnt_q == HOLD_LAST)  state_d = GB;
      end
      GB: begin
        if (!req_b)                                 state_d = req_a ? GA : IDLE;
        else if (req_a && hold_cnt_q == HOLD_LAST)  state_d = GA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter only runs while an owner keeps the mux; any transition restarts it.
  always_comb begin
    hold_cnt_d   = 4'd0;
    last_grant_d = last_grant_q;
    s_d          = s_q;
    if (state_d == state_q && state_q != IDLE) begin
      hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 4'd1;
    end
    if (state_d != state_q) begin
      if (state_d == GA) begin
        last_grant_d = 1'b0;
        s_d          = 1'b0;
      end else if (state_d == GB) begin
        last_grant_d = 1'b1;
        s_d          = 1'b1;
      end
    end
  end

  assign gnt_a   = (state_q == GA);
  assign gnt_b   = (state_q == GB);
  assign s       = s_q;
  assign f       = s_q ? b : a;
  assign f_valid = (gnt_a & req_a) | (gnt_b & req_b);

endmodule
